// File: rtl/uart_rx_pkg.sv
// Shared types and sampling offsets for the UART receive frame controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // Majority window half-width and decision offset, both relative to mid-bit edge H.
  localparam int unsigned SAMP_OFS   = 1;
  localparam int unsigned DECIDE_OFS = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter (0..prescale-1) and frame bit counter with synchronous clear.
module uart_rx_edge_bit_cnt #(
  parameter int unsigned PRESC_W = 6,
  parameter int unsigned BIT_W   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] prescale_i,
  output logic [PRESC_W-1:0] edge_cnt_o,
  output logic [BIT_W-1:0]   bit_cnt_o,
  output logic               bit_done_o
);

  logic [PRESC_W-1:0] edge_q, edge_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               last_edge;

  assign last_edge  = (edge_q == prescale_i - PRESC_W'(1));
  assign bit_done_o = en_i && last_edge;

  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (clr_i) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (en_i) begin
      if (last_edge) begin
        edge_d = '0;
        bit_d  = bit_q + BIT_W'(1);
      end else begin
        edge_d = edge_q + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detect, mid-bit sampling, LSB-first deserialise, error flags.
// Define UART_RX_MAJORITY_EN to decide each bit by 3-sample majority instead of a single sample.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  par_err,
  output logic                  samp_bit,
  output logic                  dat_chk_en,
  output logic                  par_chk_en,
  output logic                  par_typ_o,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  stp_err,
  output logic                  strt_glitch
);

  localparam int unsigned BitW = $clog2(DATA_WIDTH + 3);

  rx_state_e             state_q, state_d;
  logic [PRESC_W-1:0]    edge_cnt, half;
  logic [BitW-1:0]       bit_cnt;
  logic                  bit_done, cnt_en, cnt_clr, decide, bit_val, start_det;
  logic                  dat_stb_d, par_stb_d, valid_d, stp_d, glitch_d;
  logic                  par_en_q, par_typ_q, par_cap_q, par_flag_q;
  logic                  samp_bit_q, dat_chk_en_q, par_chk_en_q;
  logic                  data_valid_q, stp_err_q, strt_glitch_q;
  logic [DATA_WIDTH-1:0] shadow_q, p_data_q;

  assign half      = Prescale >> 1;
  assign decide    = (edge_cnt == half + PRESC_W'(DECIDE_OFS));
  assign start_det = (state_q == StIdle) && !RX_IN;
  assign cnt_en    = (state_q != StIdle) || !RX_IN;
  assign cnt_clr   = (state_q != StIdle) && (state_d == StIdle);

  uart_rx_edge_bit_cnt #(
    .PRESC_W (PRESC_W),
    .BIT_W   (BitW)
  ) u_cnt (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .en_i       (cnt_en),
    .clr_i      (cnt_clr),
    .prescale_i (Prescale),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt),
    .bit_done_o (bit_done)
  );

`ifdef UART_RX_MAJORITY_EN
  logic samp_lo_q, samp_mid_q, samp_hi_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp_lo_q  <= 1'b0;
      samp_mid_q <= 1'b0;
      samp_hi_q  <= 1'b0;
    end else begin
      if (edge_cnt == half - PRESC_W'(SAMP_OFS)) samp_lo_q <= RX_IN;
      if (edge_cnt == half) samp_mid_q <= RX_IN;
      if (edge_cnt == half + PRESC_W'(SAMP_OFS)) samp_hi_q <= RX_IN;
    end
  end

  assign bit_val = maj3(samp_lo_q, samp_mid_q, samp_hi_q);
`else
  logic samp_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp_q <= 1'b0;
    end else if (edge_cnt == half) begin
      samp_q <= RX_IN;
    end
  end

  assign bit_val = samp_q;
`endif

  always_comb begin
    state_d   = state_q;
    dat_stb_d = 1'b0;
    par_stb_d = 1'b0;
    valid_d   = 1'b0;
    stp_d     = 1'b0;
    glitch_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!RX_IN) state_d = StStart;
      end
      StStart: begin
        if (decide && bit_val) begin
          glitch_d = 1'b1;
          state_d  = StIdle;
        end else if (bit_done) begin
          state_d = StData;
        end
      end
      StData: begin
        dat_stb_d = decide;
        // bit_cnt counts frame bits, so the last data bit sits at index DATA_WIDTH.
        if (bit_done && (bit_cnt == BitW'(DATA_WIDTH))) begin
          state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        par_stb_d = decide;
        if (bit_done) state_d = StStop;
      end
      StStop: begin
        if (decide) begin
          // Leave early so a back-to-back start edge is caught during the stop bit tail.
          state_d = StIdle;
          stp_d   = !bit_val;
          valid_d = bit_val && !par_flag_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= StIdle;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      par_cap_q     <= 1'b0;
      par_flag_q    <= 1'b0;
      samp_bit_q    <= 1'b0;
      dat_chk_en_q  <= 1'b0;
      par_chk_en_q  <= 1'b0;
      data_valid_q  <= 1'b0;
      stp_err_q     <= 1'b0;
      strt_glitch_q <= 1'b0;
      shadow_q      <= '0;
      p_data_q      <= '0;
    end else begin
      state_q       <= state_d;
      dat_chk_en_q  <= dat_stb_d;
      par_chk_en_q  <= par_stb_d;
      data_valid_q  <= valid_d;
      stp_err_q     <= stp_d;
      strt_glitch_q <= glitch_d;
      par_cap_q     <= par_chk_en_q;
      if (decide && (state_q != StIdle)) samp_bit_q <= bit_val;
      if (start_det) begin
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
        par_flag_q <= 1'b0;
      end else if (par_cap_q) begin
        par_flag_q <= par_err;
      end
      if (dat_stb_d) shadow_q <= {bit_val, shadow_q[DATA_WIDTH-1:1]};
      if (valid_d) p_data_q <= shadow_q;
    end
  end

  assign samp_bit    = samp_bit_q;
  assign dat_chk_en  = dat_chk_en_q;
  assign par_chk_en  = par_chk_en_q;
  assign par_typ_o   = par_typ_q;
  assign P_DATA      = p_data_q;
  assign data_valid  = data_valid_q;
  assign stp_err     = stp_err_q;
  assign strt_glitch = strt_glitch_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: stimulus pushes expected bits/events, a negedge monitor pops.
module tb_uart_rx_fsm;

  typedef struct packed {
    logic [1:0] kind;  // 0 data_valid, 1 stp_err, 2 strt_glitch
    logic [7:0] data;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       par_err = 1'b0;
  logic       par_err_force = 1'b0;
  logic       samp_bit, dat_chk_en, par_chk_en, par_typ_o;
  logic [7:0] P_DATA;
  logic       data_valid, stp_err, strt_glitch;

  int   tests = 0;
  int   fails = 0;
  logic exp_bits[$];
  logic exp_par[$];
  ev_t  exp_ev[$];

  uart_rx_fsm #(
    .DATA_WIDTH (8),
    .PRESC_W    (6)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .Prescale    (Prescale),
    .par_err     (par_err),
    .samp_bit    (samp_bit),
    .dat_chk_en  (dat_chk_en),
    .par_chk_en  (par_chk_en),
    .par_typ_o   (par_typ_o),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .stp_err     (stp_err),
    .strt_glitch (strt_glitch)
  );

  always #5 CLK = ~CLK;

  // Stand-in for par_chk: registered error one cycle after the parity strobe.
  always @(posedge CLK) par_err <= par_chk_en & par_err_force;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got a pulse, expected none", name);
  endtask

  always @(negedge CLK) begin : monitor
    logic       b;
    ev_t        e;
    logic [1:0] k;
    if (RST) begin
      if (dat_chk_en) begin
        if (exp_bits.size() == 0) unexpected("dat_chk_en");
        else begin
          b = exp_bits.pop_front();
          check("dat_samp_bit", 32'(samp_bit), 32'(b));
        end
      end
      if (par_chk_en) begin
        if (exp_par.size() == 0) unexpected("par_chk_en");
        else begin
          b = exp_par.pop_front();
          check("par_samp_bit", 32'(samp_bit), 32'(b));
        end
      end
      if (data_valid || stp_err || strt_glitch) begin
        k = data_valid ? 2'd0 : (stp_err ? 2'd1 : 2'd2);
        check("event_onehot", 32'(data_valid) + 32'(stp_err) + 32'(strt_glitch), 32'd1);
        if (exp_ev.size() == 0) unexpected("frame_event");
        else begin
          e = exp_ev.pop_front();
          check("event_kind", 32'(k), 32'(e.kind));
          if (e.kind == 2'd0) check("p_data", 32'(P_DATA), 32'(e.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) tick();
  endtask

  task automatic idle(input int n);
    send_bit(1'b1, n);
  endtask

  // gl_bit >= 0 inverts RX_IN for the single cycle at edge H of that data bit.
  task automatic send_frame(input logic [7:0] d, input int p, input logic par_on,
                            input logic par_bit, input logic stop_bit, input logic pe,
                            input logic typ, input int gl_bit);
    Prescale      = 6'(p);
    PAR_EN        = par_on;
    PAR_TYP       = typ;
    par_err_force = pe;
    send_bit(1'b0, p);
    PAR_TYP = ~typ;
    check("par_typ_latched", 32'(par_typ_o), 32'(typ));
    for (int i = 0; i < 8; i++) begin
      exp_bits.push_back(d[i]);
      if (i == gl_bit) begin
        RX_IN = d[i];
        repeat (p / 2) tick();
        RX_IN = ~d[i];
        tick();
        RX_IN = d[i];
        repeat (p - p / 2 - 1) tick();
      end else begin
        send_bit(d[i], p);
      end
    end
    if (par_on) begin
      exp_par.push_back(par_bit);
      send_bit(par_bit, p);
    end
    if (!stop_bit) begin
      exp_ev.push_back('{kind: 2'd1, data: 8'h00});
      // The low line seen after the early exit to IDLE starts a frame whose start bit reads 1.
      exp_ev.push_back('{kind: 2'd2, data: 8'h00});
    end else if (!(par_on && pe)) begin
      exp_ev.push_back('{kind: 2'd0, data: d});
    end
    send_bit(stop_bit, p);
    par_err_force = 1'b0;
    RX_IN         = 1'b1;
  endtask

  initial begin
    repeat (3) tick();
    check("reset_outputs", 32'({samp_bit, dat_chk_en, par_chk_en, par_typ_o, data_valid,
                                stp_err, strt_glitch}), 32'd0);
    check("reset_p_data", 32'(P_DATA), 32'd0);
    RST = 1'b1;
    idle(4);

    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    idle(10);
    check("p_data_a5", 32'(P_DATA), 32'hA5);

    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    idle(20);
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, -1);
    idle(20);
    check("p_data_hold_par_err", 32'(P_DATA), 32'h3C);

    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    exp_ev.push_back('{kind: 2'd2, data: 8'h00});
    send_bit(1'b0, 2);
    idle(20);

    send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(50);
    check("p_data_after_stp_err", 32'(P_DATA), 32'h3C);
    send_frame(8'h55, 32, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    idle(10);

    send_frame(8'h12, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    send_frame(8'h34, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    idle(10);
    check("p_data_b2b", 32'(P_DATA), 32'h34);

    // Abort a frame during data bit 3; bits 0..2 have already been strobed.
    Prescale = 6'd16;
    send_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) begin
      exp_bits.push_back(1'b0);
      send_bit(1'b0, 16);
    end
    send_bit(1'b1, 2);
    RST = 1'b0;
    #1;
    check("midframe_reset_outputs", 32'({samp_bit, dat_chk_en, par_chk_en, par_typ_o, data_valid,
                                         stp_err, strt_glitch}), 32'd0);
    check("midframe_reset_p_data", 32'(P_DATA), 32'd0);
    RX_IN = 1'b1;
    repeat (3) tick();
    RST = 1'b1;
    idle(4);
    send_frame(8'h7E, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    idle(10);
    check("p_data_7e", 32'(P_DATA), 32'h7E);

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    idle(10);
    check("p_data_majority", 32'(P_DATA), 32'hC3);
`endif

    check("bits_left", exp_bits.size(), 32'd0);
    check("par_left", exp_par.size(), 32'd0);
    check("events_left", exp_ev.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
